// File: rtl/queue_pkg.sv
// Shared definitions for the 8-bit queue command interface: command codes,
// reader FSM encoding and default element width.
package queue_pkg;

  localparam int QUEUE_DW = 8;

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_TAIL = 3'b011,
    OP_POP  = 3'b100,
    OP_PUSH = 3'b101
  } queue_op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_HOLD  = 3'd4
  } reader_state_e;

endpackage

// File: rtl/queue_drain_reader.sv
// Reader-side initiator: pops elements from the queue core on request and
// presents each one on a single-entry valid/ready output stream.
module queue_drain_reader
  import queue_pkg::*;
#(
  parameter int DW      = queue_pkg::QUEUE_DW,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [DW-1:0]    q_in,
  output logic [2:0]       q_op,
  output logic             q_apply,
  input  logic [DW-1:0]    q_tail,
  input  logic             q_empty,
  input  logic             q_valid,
  output logic [DW-1:0]    out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int            TW         = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  reader_state_e    state, state_nxt;
  logic [CNT_W-1:0] remaining;
  logic             unlimited;
  logic [TW-1:0]    timer;
  logic             exhausted;
  logic             capture;

  assign exhausted = !unlimited && (remaining == '0);
  assign capture   = (state == ST_WAIT) && q_valid;
  assign q_in      = '0;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a value held and infer a latch.
  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    error     = 1'b0;
    q_apply   = 1'b0;
    q_op      = OP_NOP;
    unique case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_CHECK;
      end
      ST_CHECK: begin
        if (q_empty || exhausted) begin
          done      = 1'b1;
          state_nxt = ST_IDLE;
        end else if (out_valid && !out_ready) begin
          state_nxt = ST_HOLD;
        end else begin
          // A buffer being accepted this cycle is free in time for the response.
          state_nxt = ST_ISSUE;
        end
      end
      ST_HOLD: begin
        if (out_ready) state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        q_apply   = 1'b1;
        q_op      = OP_POP;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (q_valid) begin
          state_nxt = ST_CHECK;
        end else if (timer == TIMER_LAST) begin
          error     = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign busy = (state != ST_IDLE) && !done && !error;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remaining <= '0;
      unlimited <= 1'b0;
      timer     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if ((state == ST_IDLE) && start) begin
        remaining <= count;
        unlimited <= (count == '0);
      end else if (capture && !unlimited && (remaining != '0)) begin
        remaining <= remaining - CNT_W'(1);
      end

      if (state == ST_ISSUE) begin
        timer <= '0;
      end else if ((state == ST_WAIT) && (timer != TIMER_LAST)) begin
        timer <= timer + TW'(1);
      end

      // The buffer is always empty in WAIT, so capture never races a transfer.
      if (capture) begin
        out_data  <= q_tail;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_queue_drain_reader.sv
// Bench for queue_drain_reader: a behavioural queue stub, a per-cycle monitor
// and directed plus randomized drain scenarios.
module tb_queue_drain_reader;
  import queue_pkg::*;

  localparam int TIMEOUT = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] count;
  logic       busy, done, error;
  logic [7:0] q_in;
  logic [2:0] q_op;
  logic       q_apply;
  logic [7:0] q_tail  = 8'h00;
  logic       q_empty = 1'b1;
  logic       q_valid = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  always #5 clk = ~clk;

  queue_drain_reader #(.DW(8), .CNT_W(8), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .count(count),
    .busy(busy), .done(done), .error(error),
    .q_in(q_in), .q_op(q_op), .q_apply(q_apply),
    .q_tail(q_tail), .q_empty(q_empty), .q_valid(q_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Behavioural queue: pops on each command, answers resp_delay cycles later.
  logic [7:0] qmem[$];
  logic [7:0] exp_out[$];
  logic [7:0] rx[$];
  bit         mute       = 1'b0;
  int         resp_delay = 1;
  int         resp_cnt   = 0;
  logic [7:0] resp_val;

  int cyc = 0;
  int pops, dones, errs;
  int first_apply, apply_cyc, valid_cyc, done_cyc, err_cyc;
  bit chk_b2b = 1'b0;
  bit prev_valid = 1'b0, prev_ready = 1'b0;
  logic [7:0] prev_data;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin : stub
    q_valid = 1'b0;
    if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) begin
        q_valid = 1'b1;
        q_tail  = resp_val;
      end
    end
    if (q_apply && !rst && qmem.size() > 0) begin
      resp_val = qmem.pop_front();
      exp_out.push_back(resp_val);
      if (!mute) resp_cnt = resp_delay;
    end
    q_empty = (qmem.size() == 0);
  end

  always @(negedge clk) begin : monitor
    #1;
    if (rst) begin
      prev_valid = 1'b0;
      prev_ready = 1'b0;
    end else begin
      check("q_in_zero", q_in, 0);
      check("q_op_code", q_op, q_apply ? OP_POP : OP_NOP);
      check("done_error_excl", done & error, 0);
      if (done || error) check("busy_low_at_end", busy, 0);
      if (q_apply) begin
        if (chk_b2b && valid_cyc >= 0) check("b2b_pop_gap", cyc - valid_cyc, 2);
        if (pops == 0) first_apply = cyc;
        pops++;
        apply_cyc = cyc;
      end
      if (q_valid) valid_cyc = cyc;
      if (done)  begin dones++; done_cyc = cyc; end
      if (error) begin errs++;  err_cyc  = cyc; end
      if (prev_valid && !prev_ready) begin
        check("out_valid_held", out_valid, 1);
        check("out_data_held", out_data, prev_data);
      end
      if (out_valid && out_ready) begin
        rx.push_back(out_data);
        check("out_has_source", exp_out.size() > 0, 1);
        if (exp_out.size() > 0) check("out_order", out_data, exp_out.pop_front());
      end
      prev_valid = out_valid;
      prev_ready = out_ready;
      prev_data  = out_data;
    end
  end

  task automatic clear_stats();
    pops = 0; dones = 0; errs = 0;
    first_apply = -1; apply_cyc = -1; valid_cyc = -1; done_cyc = -1; err_cyc = -1;
    rx.delete();
    exp_out.delete();
  endtask

  task automatic pulse_start(input logic [7:0] c, output int sc);
    start = 1'b1;
    count = c;
    sc    = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_end(input bit rnd_ready);
    int n;
    n = 0;
    while (dones == 0 && errs == 0 && n < 500) begin
      @(posedge clk); #1;
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
      n++;
    end
    check("end_within_budget", (dones + errs) > 0, 1);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  int sc, r, n, c, nexp, k;
  logic [7:0] vals[$];

  initial begin
    rst = 1'b1; start = 1'b0; count = '0; out_ready = 1'b0;
    clear_stats();
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_q_apply", q_apply, 0);
    check("rst_q_op", q_op, OP_NOP);
    check("rst_q_in", q_in, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: three items, count=3, consumer always ready
    clear_stats();
    qmem = '{8'd2, 8'd4, 8'd1};
    out_ready = 1'b1; resp_delay = 1; chk_b2b = 1'b1;
    pulse_start(8'd3, sc);
    check("t1_busy_after_start", busy, 1);
    wait_end(1'b0);
    chk_b2b = 1'b0;
    drain();
    check("t1_start_to_pop", first_apply - sc, 2);
    check("t1_pops", pops, 3);
    check("t1_done", dones, 1);
    check("t1_err", errs, 0);
    check("t1_rx_count", rx.size(), 3);
    if (rx.size() == 3) begin
      check("t1_rx0", rx[0], 8'd2);
      check("t1_rx1", rx[1], 8'd4);
      check("t1_rx2", rx[2], 8'd1);
    end
    check("t1_busy_end", busy, 0);

    // 2: drain-until-empty, with a start pulse while busy that must be ignored
    clear_stats();
    qmem = '{8'h06, 8'h25};
    chk_b2b = 1'b1;
    pulse_start(8'd0, sc);
    @(posedge clk); #1;
    start = 1'b1; count = 8'd1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_end(1'b0);
    chk_b2b = 1'b0;
    drain();
    check("t2_pops", pops, 2);
    check("t2_done", dones, 1);
    check("t2_rx_count", rx.size(), 2);
    if (rx.size() == 2) begin
      check("t2_rx0", rx[0], 8'h06);
      check("t2_rx1", rx[1], 8'h25);
    end

    // 3: queue already empty
    clear_stats();
    qmem.delete();
    pulse_start(8'd5, sc);
    check("t3_done_next_cycle", done, 1);
    check("t3_busy_low", busy, 0);
    wait_end(1'b0);
    check("t3_pops", pops, 0);
    check("t3_done_latency", done_cyc - sc, 1);

    // 4: consumer stalls with the first item in the buffer
    clear_stats();
    qmem = '{8'h11, 8'h22, 8'h33};
    out_ready = 1'b0; resp_delay = 2;
    pulse_start(8'd2, sc);
    n = 0;
    while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
    check("t4_first_item", out_valid, 1);
    repeat (10) @(posedge clk);
    #1;
    check("t4_no_pop_while_full", pops, 1);
    check("t4_valid_held", out_valid, 1);
    check("t4_data_held", out_data, 8'h11);
    out_ready = 1'b1;
    r = cyc;
    wait_end(1'b0);
    drain();
    check("t4_pop_after_ready", apply_cyc - r, 1);
    check("t4_pops", pops, 2);
    check("t4_rx_count", rx.size(), 2);
    if (rx.size() == 2) check("t4_rx1", rx[1], 8'h22);
    qmem.delete();

    // 5: queue never answers
    clear_stats();
    qmem = '{8'h5A};
    mute = 1'b1; resp_delay = 1;
    pulse_start(8'd1, sc);
    wait_end(1'b0);
    check("t5_error", errs, 1);
    check("t5_no_done", dones, 0);
    check("t5_timeout_cycles", err_cyc - first_apply, TIMEOUT);
    check("t5_busy_end", busy, 0);
    check("t5_no_out", out_valid, 0);
    mute = 1'b0;

    // 6: reset while waiting; the late response must be dropped
    clear_stats();
    qmem = '{8'h61, 8'h62, 8'h63};
    resp_delay = 6;
    pulse_start(8'd0, sc);
    n = 0;
    while (pops == 0 && n < 50) begin @(posedge clk); #1; n++; end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("t6_rst_busy", busy, 0);
    check("t6_rst_q_apply", q_apply, 0);
    check("t6_rst_q_op", q_op, OP_NOP);
    check("t6_rst_out_valid", out_valid, 0);
    check("t6_rst_out_data", out_data, 0);
    check("t6_rst_done_err", {done, error}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("t6_late_valid_ignored", out_valid, 0);
    check("t6_idle_after_late", busy, 0);
    clear_stats();
    resp_delay = 1;
    pulse_start(8'd2, sc);
    wait_end(1'b0);
    drain();
    check("t6_pops_after_rst", pops, 2);
    check("t6_done_after_rst", dones, 1);
    check("t6_rx_count", rx.size(), 2);
    if (rx.size() == 2) begin
      check("t6_rx0", rx[0], 8'h62);
      check("t6_rx1", rx[1], 8'h63);
    end

    // Randomized drains against the expected item list
    for (int it = 0; it < 40; it++) begin
      clear_stats();
      qmem.delete();
      vals.delete();
      n = $urandom_range(0, 6);
      c = $urandom_range(0, 7);
      for (int j = 0; j < n; j++) vals.push_back(8'($urandom));
      qmem = vals;
      resp_delay = $urandom_range(1, 4);
      nexp = (c == 0 || c > n) ? n : c;
      pulse_start(8'(c), sc);
      wait_end(1'b1);
      drain();
      check("rnd_pops", pops, nexp);
      check("rnd_done", dones, 1);
      check("rnd_err", errs, 0);
      check("rnd_rx_count", rx.size(), nexp);
      for (k = 0; k < nexp && k < rx.size(); k++) check("rnd_rx_data", rx[k], vals[k]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
